// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage and its register file.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    localparam int          REG_COUNT = 32;
    localparam logic [4:0]  REG_A0    = 5'd10;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB-to-writeback bus plus decode read ports; master = pipeline side, slave = wb_stage.
interface wb_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 64
);
    logic                  ValidW;
    logic                  RegWriteW;
    logic [1:0]            ResultSrcW;
    logic [ADDR_WIDTH-1:0] RdW;
    logic [DATA_WIDTH-1:0] ALUResultW;
    logic [DATA_WIDTH-1:0] ReadDataW;
    logic [DATA_WIDTH-1:0] PCPlus4W;
    logic [ADDR_WIDTH-1:0] A1;
    logic [ADDR_WIDTH-1:0] A2;
    logic [DATA_WIDTH-1:0] RD1;
    logic [DATA_WIDTH-1:0] RD2;
    logic [DATA_WIDTH-1:0] ResultW;
    logic                  WbEnW;
    logic [DATA_WIDTH-1:0] A0;
    logic [CNT_WIDTH-1:0]  CycleCount;
    logic [CNT_WIDTH-1:0]  InstRetCount;

    modport master (
        output ValidW, RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W, A1, A2,
        input  RD1, RD2, ResultW, WbEnW, A0, CycleCount, InstRetCount
    );

    modport slave (
        input  ValidW, RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W, A1, A2,
        output RD1, RD2, ResultW, WbEnW, A0, CycleCount, InstRetCount
    );
endinterface

// File: rtl/wb_stage_reg_file.sv
// Architectural register file: x0 reads as zero, two combinational read ports, one write port.
// Define WB_BYPASS_EN for same-cycle write-through on the read ports.
module reg_file
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr1_i,
    input  logic [ADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o,
    output logic [DATA_WIDTH-1:0] a0_o
);
    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] readPort(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] value;
        value = (addr == '0) ? '0 : regs_q[addr];
`ifdef WB_BYPASS_EN
        // Write-before-read: a commit this cycle is already visible to decode.
        if (we_i && (waddr_i != '0) && (waddr_i == addr)) begin
            value = wdata_i;
        end
`endif
        return value;
    endfunction

    assign rdata1_o = readPort(raddr1_i);
    assign rdata2_o = readPort(raddr2_i);
    assign a0_o     = regs_q[ADDR_WIDTH'(REG_A0)];

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select, register commit, retired-instruction and cycle counters.
// Optional WB_BYPASS_EN enables register-file write-through (see reg_file).
module wb_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 64
) (
    input  logic     clk,
    input  logic     rst,
    wb_stage_if.slave bus
);
    logic [DATA_WIDTH-1:0] resultW;
    logic                  wbEnW;
    logic [CNT_WIDTH-1:0]  cycleCount_q, cycleCount_d;
    logic [CNT_WIDTH-1:0]  instRetCount_q, instRetCount_d;

    // Encoding 2'b11 is reserved and falls back to the ALU result.
    always_comb begin
        resultW = bus.ALUResultW;
        case (result_src_t'(bus.ResultSrcW))
            RES_MEM: resultW = bus.ReadDataW;
            RES_PC4: resultW = bus.PCPlus4W;
            default: resultW = bus.ALUResultW;
        endcase
    end

    assign wbEnW = bus.ValidW & bus.RegWriteW & (bus.RdW != ADDR_WIDTH'(REG_ZERO)) & ~rst;

    always_comb begin
        cycleCount_d   = cycleCount_q + CNT_WIDTH'(1);
        instRetCount_d = instRetCount_q;
        if (bus.ValidW) begin
            instRetCount_d = instRetCount_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycleCount_q   <= '0;
            instRetCount_q <= '0;
        end else begin
            cycleCount_q   <= cycleCount_d;
            instRetCount_q <= instRetCount_d;
        end
    end

    reg_file #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wbEnW),
        .waddr_i  (bus.RdW),
        .wdata_i  (resultW),
        .raddr1_i (bus.A1),
        .raddr2_i (bus.A2),
        .rdata1_o (bus.RD1),
        .rdata2_o (bus.RD2),
        .a0_o     (bus.A0)
    );

    assign bus.ResultW      = resultW;
    assign bus.WbEnW        = wbEnW;
    assign bus.CycleCount   = cycleCount_q;
    assign bus.InstRetCount = instRetCount_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: architectural model compared every cycle plus directed literals.
module tb_wb_stage;
    import pipeline_pkg::*;

    logic clk;
    logic rst;

    wb_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(64)) bus ();

    wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;
    bit done = 1'b0;

    logic [31:0] mRegs [REG_COUNT];
    logic [63:0] mCycle = '0;
    logic [63:0] mInstRet = '0;

    function automatic logic [31:0] expResult();
        if (bus.ResultSrcW == 2'b01) return bus.ReadDataW;
        if (bus.ResultSrcW == 2'b10) return bus.PCPlus4W;
        return bus.ALUResultW;
    endfunction

    function automatic logic expWbEn();
        return bus.ValidW && bus.RegWriteW && (bus.RdW != 5'd0) && !rst;
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (expWbEn() && (a == bus.RdW)) return expResult();
`endif
        return mRegs[a];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic rw, input logic [1:0] src,
                                 input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                                 input logic [31:0] pc4, input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        #2;
        rst            = r;
        bus.ValidW     = v;
        bus.RegWriteW  = rw;
        bus.ResultSrcW = src;
        bus.RdW        = rd;
        bus.ALUResultW = alu;
        bus.ReadDataW  = rdata;
        bus.PCPlus4W   = pc4;
        bus.A1         = a1;
        bus.A2         = a2;
        #1;
    endtask

    // Architectural model: commits and counts at each rising edge from the inputs then present.
    initial begin
        for (int i = 0; i < REG_COUNT; i++) mRegs[i] = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < REG_COUNT; i++) mRegs[i] = '0;
                mCycle   = '0;
                mInstRet = '0;
            end else begin
                if (expWbEn()) mRegs[bus.RdW] = expResult();
                mCycle = mCycle + 64'd1;
                if (bus.ValidW) mInstRet = mInstRet + 64'd1;
            end
        end
    end

    // Every-cycle comparison against the model, before the next stimulus is applied.
    initial begin
        while (!done) begin
            @(negedge clk);
            if (checkEn && !done) begin
                checkOutput("RD1", 64'(bus.RD1), 64'(expRead(bus.A1)));
                checkOutput("RD2", 64'(bus.RD2), 64'(expRead(bus.A2)));
                checkOutput("A0", 64'(bus.A0), 64'(mRegs[10]));
                checkOutput("ResultW", 64'(bus.ResultW), 64'(expResult()));
                checkOutput("WbEnW", 64'(bus.WbEnW), 64'(expWbEn()));
                checkOutput("CycleCount", bus.CycleCount, mCycle);
                checkOutput("InstRetCount", bus.InstRetCount, mInstRet);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.ValidW = 0; bus.RegWriteW = 0; bus.ResultSrcW = 0; bus.RdW = 0;
        bus.ALUResultW = 0; bus.ReadDataW = 0; bus.PCPlus4W = 0; bus.A1 = 0; bus.A2 = 0;

        applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("reset RD1", 64'(bus.RD1), 64'd0);
        checkOutput("reset RD2", 64'(bus.RD2), 64'd0);
        checkOutput("reset A0", 64'(bus.A0), 64'd0);
        checkOutput("reset CycleCount", bus.CycleCount, 64'd0);
        checkOutput("reset InstRetCount", bus.InstRetCount, 64'd0);
        checkEn = 1'b1;

        // ALU result into x5, read back the following cycle.
        applyStimulus(0, 1, 1, 2'b00, 5'd5, 32'hDEADBEEF, 0, 0, 5'd5, 0);
        checkOutput("x5 WbEnW", 64'(bus.WbEnW), 64'd1);
        checkOutput("x5 ResultW", 64'(bus.ResultW), 64'hDEADBEEF);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 5'd5, 0);
        checkOutput("x5 RD1", 64'(bus.RD1), 64'hDEADBEEF);
        checkOutput("x5 InstRetCount", bus.InstRetCount, 64'd1);
        checkOutput("x5 CycleCount", bus.CycleCount, 64'd2);

        // Write to x0 must be suppressed.
        applyStimulus(0, 1, 1, 2'b01, 5'd0, 0, 32'h1234, 0, 5'd0, 0);
        checkOutput("x0 WbEnW", 64'(bus.WbEnW), 64'd0);
        checkOutput("x0 ResultW", 64'(bus.ResultW), 64'h1234);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 5'd0, 0);
        checkOutput("x0 RD1", 64'(bus.RD1), 64'd0);
        checkOutput("x0 InstRetCount", bus.InstRetCount, 64'd2);

        // Link address into a0, then a bubble with RegWriteW set.
        applyStimulus(0, 1, 1, 2'b10, 5'd10, 0, 0, 32'h0000_0104, 0, 0);
        checkOutput("a0 ResultW", 64'(bus.ResultW), 64'h104);
        applyStimulus(0, 0, 1, 2'b00, 5'd10, 32'hFFFF, 0, 0, 0, 0);
        checkOutput("a0 A0", 64'(bus.A0), 64'h104);
        checkOutput("bubble WbEnW", 64'(bus.WbEnW), 64'd0);
        checkOutput("a0 InstRetCount", bus.InstRetCount, 64'd3);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("bubble A0", 64'(bus.A0), 64'h104);
        checkOutput("bubble InstRetCount", bus.InstRetCount, 64'd3);

        // Same-cycle read of a register being written.
        applyStimulus(0, 1, 1, 2'b00, 5'd7, 32'hA5A5, 0, 0, 0, 5'd7);
`ifdef WB_BYPASS_EN
        checkOutput("x7 same-cycle RD2", 64'(bus.RD2), 64'hA5A5);
`else
        checkOutput("x7 same-cycle RD2", 64'(bus.RD2), 64'd0);
`endif
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5'd7);
        checkOutput("x7 next-cycle RD2", 64'(bus.RD2), 64'hA5A5);
        checkOutput("x7 InstRetCount", bus.InstRetCount, 64'd4);

        // Counter wrap: preload all-ones, retire a store.
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        force dut.instRetCount_q = {64{1'b1}};
        mInstRet = {64{1'b1}};
        #1;
        release dut.instRetCount_q;
        checkOutput("preload InstRetCount", bus.InstRetCount, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(0, 1, 0, 2'b00, 5'd9, 32'h55, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("wrap InstRetCount", bus.InstRetCount, 64'd0);

        // Reset with a write pending.
        applyStimulus(1, 1, 1, 2'b00, 5'd3, 32'h77, 0, 0, 5'd3, 5'd5);
        checkOutput("rst WbEnW", 64'(bus.WbEnW), 64'd0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 5'd3, 5'd5);
        checkOutput("post-rst RD1", 64'(bus.RD1), 64'd0);
        checkOutput("post-rst RD2", 64'(bus.RD2), 64'd0);
        checkOutput("post-rst A0", 64'(bus.A0), 64'd0);
        checkOutput("post-rst CycleCount", bus.CycleCount, 64'd0);
        checkOutput("post-rst InstRetCount", bus.InstRetCount, 64'd0);

        // Mixed traffic with frequent read-after-write address matches.
        for (int i = 0; i < 40; i++) begin
            logic [4:0] rd;
            logic [4:0] a1;
            logic [4:0] a2;
            rd = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), rd, $urandom, $urandom, $urandom, a1, a2);
        end
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 5'd10, 0);
        @(negedge clk);
        #3;
        done = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
